// File: rtl/phys_reg_free_list_pkg.sv
// Shared sizing and types for the physical register free list.
package FreeListTypes;

  localparam int PREG_NUM_DEFAULT = 64;
  localparam int LREG_NUM_DEFAULT = 32;
  localparam int FREE_LIST_CAP    = PREG_NUM_DEFAULT - LREG_NUM_DEFAULT;

  typedef logic [$clog2(PREG_NUM_DEFAULT)-1:0] PRegNumPath;
  typedef logic [$clog2(FREE_LIST_CAP)-1:0]    FreeListIndexPath;
  typedef logic [$clog2(FREE_LIST_CAP+1)-1:0]  FreeListCountPath;

  typedef struct packed {
    PRegNumPath pReg;
  } FreeListEntry;

endpackage

// File: rtl/phys_reg_free_list_checker.sv
// Protocol assertions for the free list: pop overrun, push overflow and
// (when enabled) duplicate release.
module phys_reg_free_list_checker #(
  parameter int CW  = 6,
  parameter int POW = 2,
  parameter int PUW = 2,
  parameter int CAP = 32
) (
  input logic          clk,
  input logic          rst,
  input logic [POW-1:0] i_popRaw,
  input logic [CW:0]    i_popNum,
  input logic [PUW-1:0] i_pushRaw,
  input logic [CW-1:0]  i_count,
  input logic           i_dupEvent
);

  a_pop_overrun: assert property (@(posedge clk) disable iff (!rst)
    (CW+1)'(i_popRaw) <= {1'b0, i_count});

  a_push_overflow: assert property (@(posedge clk) disable iff (!rst)
    ({1'b0, i_count} + (CW+1)'(i_pushRaw) - i_popNum) <= (CW+1)'(CAP));

  a_double_free: assert property (@(posedge clk) disable iff (!rst)
    !i_dupEvent);

endmodule

// File: rtl/phys_reg_free_list_lane_compactor.sv
// Turns a sparse lane-valid mask into per-lane slot offsets (number of valid
// lanes below each lane) and the total number of valid lanes.
module free_list_lane_compactor #(
  parameter  int WIDTH = 2,
  localparam int OW    = $clog2(WIDTH + 1)
) (
  input  logic [WIDTH-1:0]         i_valid,
  output logic [WIDTH-1:0][OW-1:0] o_offset,
  output logic [OW-1:0]            o_count
);

  logic [OW-1:0] w_acc;

  // Running prefix count of valid lanes.
  always_comb begin
    w_acc    = '0;
    o_offset = '0;
    for (int i = 0; i < WIDTH; i++) begin
      o_offset[i] = w_acc;
      w_acc       = w_acc + OW'(i_valid[i]);
    end
    o_count = w_acc;
  end

endmodule

// File: rtl/phys_reg_free_list.sv
// Circular free list of physical registers feeding rename, refilled by the
// committer's release lanes. Optional duplicate-release tracking is built
// when RSD_FREE_LIST_DOUBLE_FREE_CHECK_EN is defined.
module phys_reg_free_list
  import FreeListTypes::*;
#(
  parameter  int PREG_NUM   = PREG_NUM_DEFAULT,
  parameter  int LREG_NUM   = LREG_NUM_DEFAULT,
  parameter  int PUSH_WIDTH = 2,
  parameter  int POP_WIDTH  = 2,
  localparam int CAP        = PREG_NUM - LREG_NUM,
  localparam int PW         = $clog2(PREG_NUM),
  localparam int CW         = $clog2(CAP + 1)
) (
  input  logic                           clk,
  input  logic                           rst,
  input  logic [PUSH_WIDTH-1:0]          releaseReg,
  input  logic [PUSH_WIDTH-1:0][PW-1:0]  phyReleasedReg,
  input  logic [POP_WIDTH-1:0]           allocReq,
  output logic [POP_WIDTH-1:0][PW-1:0]   allocRegNum,
  output logic [CW-1:0]                  freeNum,
  output logic                           allocStall,
  output logic                           doubleFree
);

  localparam int IW  = (CAP > 1) ? $clog2(CAP) : 1;
  localparam int PUW = $clog2(PUSH_WIDTH + 1);
  localparam int POW = $clog2(POP_WIDTH + 1);
  localparam logic [IW:0] CAP_IDX = (IW+1)'(CAP);
  localparam logic [CW:0] CAP_CNT = (CW+1)'(CAP);

  logic [PW-1:0] r_entry [CAP];
  logic [IW-1:0] r_head;
  logic [IW-1:0] r_tail;
  logic [CW-1:0] r_count;
  logic          r_allocStall;

  logic [POP_WIDTH-1:0][POW-1:0]  w_popOff;
  logic [POW-1:0]                 w_popRaw;
  logic [PUSH_WIDTH-1:0][PUW-1:0] w_pushOff;
  logic [PUW-1:0]                 w_pushRaw;
  logic [CW:0]                    w_popNum;
  logic [CW:0]                    w_countSum;
  logic [CW:0]                    w_countNext;
  logic                           w_pushOk;
  logic [IW:0]                    w_pushAdv;
  logic [PUSH_WIDTH-1:0][IW-1:0]  w_wrIdx;
  logic                           w_dupEvent;

  // Pointer arithmetic modulo CAP; CAP need not be a power of two.
  function automatic logic [IW-1:0] wrap_add(input logic [IW-1:0] base, input logic [IW:0] off);
    logic [IW:0] sum;
    sum = {1'b0, base} + off;
    return (sum >= CAP_IDX) ? IW'(sum - CAP_IDX) : IW'(sum);
  endfunction

  free_list_lane_compactor #(.WIDTH(POP_WIDTH)) u_pop_compactor (
    .i_valid  (allocReq),
    .o_offset (w_popOff),
    .o_count  (w_popRaw)
  );

  free_list_lane_compactor #(.WIDTH(PUSH_WIDTH)) u_push_compactor (
    .i_valid  (releaseReg),
    .o_offset (w_pushOff),
    .o_count  (w_pushRaw)
  );

  // Pop clamps to the available count; a push that would overflow is dropped.
  always_comb begin
    w_popNum    = ((CW+1)'(w_popRaw) > {1'b0, r_count}) ? {1'b0, r_count} : (CW+1)'(w_popRaw);
    w_countSum  = {1'b0, r_count} + (CW+1)'(w_pushRaw) - w_popNum;
    w_pushOk    = (w_countSum <= CAP_CNT);
    w_countNext = w_pushOk ? w_countSum : ({1'b0, r_count} - w_popNum);
    w_pushAdv   = w_pushOk ? (IW+1)'(w_pushRaw) : '0;
    for (int i = 0; i < POP_WIDTH; i++) begin
      allocRegNum[i] = r_entry[wrap_add(r_head, (IW+1)'(w_popOff[i]))];
    end
    for (int k = 0; k < PUSH_WIDTH; k++) begin
      w_wrIdx[k] = wrap_add(r_tail, (IW+1)'(w_pushOff[k]));
    end
  end

  // Entry storage, pointers and count.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < CAP; i++) begin
        r_entry[i] <= PW'(LREG_NUM + i);
      end
      r_head       <= '0;
      r_tail       <= '0;
      r_count      <= CW'(CAP);
      r_allocStall <= 1'b0;
    end else begin
      for (int k = 0; k < PUSH_WIDTH; k++) begin
        if (w_pushOk && releaseReg[k]) begin
          r_entry[w_wrIdx[k]] <= phyReleasedReg[k];
        end
      end
      r_head       <= wrap_add(r_head, (IW+1)'(w_popNum));
      r_tail       <= wrap_add(r_tail, w_pushAdv);
      r_count      <= w_countNext[CW-1:0];
      r_allocStall <= (w_countNext < (CW+1)'(POP_WIDTH));
    end
  end

  assign freeNum    = r_count;
  assign allocStall = r_allocStall;

`ifdef RSD_FREE_LIST_DOUBLE_FREE_CHECK_EN
  logic [PREG_NUM-1:0] r_freeMask;
  logic [PREG_NUM-1:0] w_maskNext;
  logic                r_doubleFree;
  logic [POP_WIDTH-1:0] w_popServed;

  // Track which registers are free; flag a release of an already-free register.
  always_comb begin
    w_maskNext = r_freeMask;
    w_dupEvent = 1'b0;
    for (int i = 0; i < POP_WIDTH; i++) begin
      w_popServed[i] = allocReq[i] && ((CW+1)'(w_popOff[i]) < w_popNum);
      w_maskNext[allocRegNum[i]] = w_popServed[i] ? 1'b0 : w_maskNext[allocRegNum[i]];
    end
    for (int k = 0; k < PUSH_WIDTH; k++) begin
      w_dupEvent = w_dupEvent | (releaseReg[k] && r_freeMask[phyReleasedReg[k]]);
      for (int j = 0; j < k; j++) begin
        w_dupEvent = w_dupEvent |
          (releaseReg[k] && releaseReg[j] && (phyReleasedReg[j] == phyReleasedReg[k]));
      end
      w_maskNext[phyReleasedReg[k]] =
        (w_pushOk && releaseReg[k]) ? 1'b1 : w_maskNext[phyReleasedReg[k]];
    end
  end

  // Free mask and sticky double-free flag.
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int r = 0; r < PREG_NUM; r++) begin
        r_freeMask[r] <= (r >= LREG_NUM) ? 1'b1 : 1'b0;
      end
      r_doubleFree <= 1'b0;
    end else begin
      r_freeMask   <= w_maskNext;
      r_doubleFree <= r_doubleFree | w_dupEvent;
    end
  end

  assign doubleFree = r_doubleFree;
`else
  assign w_dupEvent = 1'b0;
  assign doubleFree = 1'b0;
`endif

  phys_reg_free_list_checker #(
    .CW  (CW),
    .POW (POW),
    .PUW (PUW),
    .CAP (CAP)
  ) u_checker (
    .clk        (clk),
    .rst        (rst),
    .i_popRaw   (w_popRaw),
    .i_popNum   (w_popNum),
    .i_pushRaw  (w_pushRaw),
    .i_count    (r_count),
    .i_dupEvent (w_dupEvent)
  );

endmodule
